// File: rtl/pzbcm_fifo_data_path.sv
// pzbcm_fifo_data_path: FIFO word storage, head-of-queue output stage and optional parity check
module pzbcm_fifo_data_path #(
    parameter type TYPE              = logic,
    parameter int  DEPTH             = 8,
    parameter bit  DATA_FF_OUT       = 1,
    parameter int  RAM_WORDS         = DATA_FF_OUT ? DEPTH - 1 : DEPTH,
    parameter int  RAM_POINTER_WIDTH = (RAM_WORDS >= 2) ? $clog2(RAM_WORDS) : 1,
    parameter bit  PARITY            = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  TYPE                          i_data,
    input  logic                         i_write_to_ff,
    input  logic                         i_write_to_ram,
    input  logic [RAM_POINTER_WIDTH-1:0] i_write_pointer,
    input  logic                         i_read_from_ram,
    input  logic [RAM_POINTER_WIDTH-1:0] i_read_pointer,
    output TYPE                          o_data,
    output logic                         o_parity_error,
    input  logic                         i_check
);
    localparam int W  = $bits(TYPE);
    localparam int SW = W + (PARITY ? 1 : 0);

    logic [W-1:0]                 in_bits;
    logic [SW-1:0]                wr_word;
    logic [SW-1:0]                rd_word;
    logic [SW-1:0]                out_word;
    logic [RAM_POINTER_WIDTH-1:0] wr_ptr;
    logic [RAM_POINTER_WIDTH-1:0] rd_ptr;
    logic [SW-1:0]                ram [RAM_WORDS];
    logic                         unused_ok;

    assign in_bits   = i_data;
    assign unused_ok = ^{i_write_pointer, i_read_pointer, i_write_to_ff, i_read_from_ram, i_check};

    // The stored word carries its even-parity bit on top when parity is enabled
    if (PARITY) begin : g_wr_par
        assign wr_word = {^in_bits, in_bits};
    end else begin : g_wr_raw
        assign wr_word = in_bits;
    end

    // A single-entry RAM has no meaningful address, so entry 0 is always used
    assign wr_ptr  = (RAM_WORDS == 1) ? '0 : i_write_pointer;
    assign rd_ptr  = (RAM_WORDS == 1) ? '0 : i_read_pointer;
    assign rd_word = ram[rd_ptr];

    // RAM write port; no reset, contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (i_write_to_ram) ram[wr_ptr] <= wr_word;
    end

    if (DATA_FF_OUT) begin : g_ff
        logic [SW-1:0] data_ff;
        // Head register: clear wins, then a direct push, then a refill from RAM
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)             data_ff <= '0;
            else if (i_clear)         data_ff <= '0;
            else if (i_write_to_ff)   data_ff <= wr_word;
            else if (i_read_from_ram) data_ff <= rd_word;
        end
        assign out_word = data_ff;
        a_steer_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            !(i_write_to_ff && i_read_from_ram));
    end else begin : g_comb
        assign out_word = rd_word;
    end

    assign o_data = out_word[W-1:0];

    if (PARITY) begin : g_par
        logic err;
        // Sticky flag: any odd-parity presented word under i_check sets it until clear/reset
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)                    err <= 1'b0;
            else if (i_clear)                err <= 1'b0;
            else if (i_check && ^out_word)   err <= 1'b1;
        end
        assign o_parity_error = err;
    end else begin : g_no_par
        assign o_parity_error = 1'b0;
    end

    if (RAM_WORDS > 1) begin : g_ptr_chk
        a_wr_ptr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            i_write_to_ram |-> (int'(i_write_pointer) < RAM_WORDS));
        a_rd_ptr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (i_read_from_ram || !DATA_FF_OUT) |-> (int'(i_read_pointer) < RAM_WORDS));
    end
endmodule

// File: doc/pzbcm_fifo_data_path.md
# pzbcm_fifo_data_path

Storage and output stage of the pzbcm FIFO, directly downstream of the FIFO controller. It consumes the controller's write/read steering signals and RAM pointers, holds the FIFO words in a flop-based RAM plus an optional output register, and presents the head-of-queue word on `o_data`. An optional per-word parity bit is stored with each entry and checked at the output, with a sticky error flag.

## Interface
Parameters:
- TYPE, logic: data word type; W = $bits(TYPE).
- DEPTH, 8: total FIFO depth. Must match the controller.
- DATA_FF_OUT, 1: 1 = head word held in an output FF; 0 = `o_data` read combinationally from RAM.
- RAM_WORDS, DATA_FF_OUT ? DEPTH-1 : DEPTH: RAM entries. Must be ≥1.
- RAM_POINTER_WIDTH, RAM_WORDS≥2 ? $clog2(RAM_WORDS) : 1: pointer width.
- PARITY, 0: 1 = store and check an even-parity bit per word.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_clear  in  1  synchronous clear of the output FF and error flag.
- i_data  in  W  push data.
- i_write_to_ff  in  1  load `i_data` into the output FF.
- i_write_to_ram  in  1  write `i_data` to RAM[`i_write_pointer`].
- i_write_pointer  in  RAM_POINTER_WIDTH  RAM write address.
- i_read_from_ram  in  1  move RAM[`i_read_pointer`] into the output FF.
- i_read_pointer  in  RAM_POINTER_WIDTH  RAM read address.
- o_data  out  W  head-of-queue word.
- o_parity_error  out  1  sticky parity mismatch on the presented word.
- i_check  in  1  qualifier for the parity check: controller not empty and pop or presenting.

## Operation
- **RAM writes**
  - When `i_write_to_ram` is high: RAM[`i_write_pointer`] <= {parity(`i_data`), `i_data`} at the clock edge.
  - RAM has no reset and is not cleared; contents are don't-care until written.
- **DATA_FF_OUT=1**
  - When `i_write_to_ff` is high: `data_ff` <= `i_data` (with its parity).
  - Else when `i_read_from_ram` is high: `data_ff` <= RAM[`i_read_pointer`].
  - Otherwise `data_ff` holds.
  - `o_data` = `data_ff`.
  - `i_write_to_ff` and `i_read_from_ram` asserted together is illegal. Flag it with an assertion; `write_to_ff` wins.
- **DATA_FF_OUT=0**
  - `o_data` = RAM[`i_read_pointer`] combinationally.
  - `i_write_to_ff` and `i_read_from_ram` are ignored.
- **RAM_WORDS=1**: pointers are ignored and entry 0 is always used.
- **Simultaneous read and write at the same address**: the read returns the pre-write contents. The new word lands in RAM only.
- **Parity (PARITY=1)**
  - Stored bit = ^`i_data`.
  - Mismatch = (^`o_data` != stored bit) && `i_check`.
  - `o_parity_error` sets on a mismatch and stays set until `i_clear` or reset.
  - With PARITY=0, `o_parity_error` is tied to 0 and no parity storage is built.
- **`i_clear`**: `data_ff` <= 0 and `o_parity_error` <= 0. Clear has priority over writes in the same cycle. RAM is untouched.

## Timing
- **Reset values**: `o_data` = 0 when DATA_FF_OUT=1 (RAM-dependent when DATA_FF_OUT=0); `o_parity_error` = 0; `data_ff` parity bit = 0, which is consistent with zero data.
- **Push to empty FIFO**: the word is visible on `o_data` one cycle after the push edge (`write_to_ff`).
- **Pop with count ≥ 2**: the next word is visible the cycle after the pop edge. No bubble.
- **RAM write to readable**: data written at edge N is readable from RAM in cycle N+1.
- **Parity error timing**: the flag rises at the edge following the checked cycle.
- **Reset mid-operation**: `data_ff` and the flag are forced to 0 asynchronously. Stale RAM words are harmless because the controller pointers also reset.
- **Pointer range**: pointers are used as-is. Wrap-around is handled by the controller. An out-of-range pointer (≥ RAM_WORDS) is an assertion failure.

## Test plan
- **DEPTH=8, DATA_FF_OUT=1**: push 0x11 into empty (`write_to_ff`) → `o_data`=0x11 next cycle. Push 0x22 and 0x33 into RAM[0] and RAM[1]; pop (`read_from_ram`, ptr 0) → `o_data`=0x22; pop (ptr 1) → 0x33.
- **Wrap-around**: 20 push/pop pairs cycling write pointers 0..6 → `o_data` sequence equals the push sequence with no loss or duplication.
- **DEPTH=2, RAM_WORDS=1, simultaneous pop+push** at ptr 0 holding 0xA5, new data 0x5A → `o_data`=0xA5 next cycle; a following pop → 0x5A.
- **DATA_FF_OUT=0**: write 0x7E to RAM[3] with read ptr=3 → `o_data`=0x7E in the cycle after the write edge.
- **PARITY=1**: force-flip a RAM data bit of an entry, then read it with `i_check`=1 → `o_parity_error`=1 next cycle and stays 1. Pulse `i_clear` → returns to 0.
- **Reset and clear**: assert `i_rst_n`=0 asynchronously mid-burst → `o_data`=0 and `o_parity_error`=0 immediately. Assert `i_clear` and `i_write_to_ff` together → `o_data`=0.
